serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller: accepts two WIDTH-bit operands over a valid/ready

---
 rtl/serial_add_ctrl_if.sv | 36 +++
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshake bundle
// for the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder
// bit per cycle, LSB first, valid/ready in and out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  serial_add_ctrl_if.slave  bus,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_step;
  logic w_last;
  logic w_in_ready;
  logic w_out_valid;
  logic w_busy;
  logic w_s0;
  logic w_c0;
  logic w_s1;
  logic w_c1;
  logic w_cnext;

  // Full adder from two half-adder stages.
  assign w_s0    = r_a_sr[0] ^ r_b_sr[0];
  assign w_c0    = r_a_sr[0] & r_b_sr[0];
  assign w_s1    = w_s0 ^ r_carry;
  assign w_c1    = w_s0 & r_carry;
  assign w_cnext = w_c0 | w_c1;
  assign w_last  = (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs; clr wins.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (clr) begin
          w_next = S_IDLE;
        end else if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (clr) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (clr || bus.out_ready)
          w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand shift registers, LSB consumed first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
    end else if (w_accept) begin
      r_a_sr <= bus.a;
      r_b_sr <= bus.b;
    end else if (w_step) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
    end
  end

  // Carry and bit counter; flushed on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (clr || w_accept) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_carry <= w_cnext;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result shifts in from the MSB end; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_step) begin
      r_sum <= {w_s1, r_sum[WIDTH-1:1]};
      if (w_last) r_cout <= w_cnext;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign busy          = w_busy;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl
// with directed operand vectors, WIDTH=8.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb[$];

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h",
                 {bus.cout, bus.sum});
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({bus.cout, bus.sum} !== e) begin
          errors++;
          $display("FAIL result got=%h exp=%h",
                   {bus.cout, bus.sum}, e);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, exp);
    end
  endtask

  // Offer operands until accepted; caller is
  // 1 time unit after a rising edge.
  task automatic send(input logic [7:0] xa,
                      input logic [7:0] xb,
                      input logic [8:0] exp,
                      input bit push,
                      output int acc);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = xa;
    bus.b = xb;
    while (!got && n < 50) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.in_valid = 1'b0;
    acc = cyc;
    if (!got) begin
      chk("accept_timeout", 32'(n), 32'd0);
    end else if (push) begin
      sb.push_back(exp);
    end
  endtask

  // Count edges from accept to out_valid.
  task automatic wait_out(output int k);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic op_wait(input logic [7:0] xa,
                         input logic [7:0] xb,
                         input logic [8:0] exp);
    int acc;
    int k;
    send(xa, xb, exp, 1'b1, acc);
    wait_out(k);
    chk("latency", 32'(k), 32'd8);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] r;
  } vec_t;

  vec_t bb[6];
  int   acc_t[6];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    int bad;

    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add, latency and out_valid drop.
    send(8'h0F, 8'h01, 9'h010, 1'b1, acc);
    wait_out(k);
    chk("latency_first", 32'(k), 32'd8);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ov_drop", 32'(bus.out_valid), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    op_wait(8'hFF, 8'h01, 9'h100);
    op_wait(8'hFF, 8'hFF, 9'h1FE);

    // Consumer stall: result held 5 cycles.
    bus.out_ready = 1'b0;
    send(8'h99, 8'h77, 9'h110, 1'b1, acc);
    wait_out(k);
    chk("latency_stall", 32'(k), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_ov", 32'(bus.out_valid), 32'd1);
      chk("stall_res",
          32'({bus.cout, bus.sum}), 32'h110);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // clr on 4th RUN cycle aborts the operation.
    send(8'hAA, 8'h55, 9'h0FF, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_ov", 32'(bus.out_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("clr_no_result", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    op_wait(8'h12, 8'h34, 9'h046);

    // clr with in_valid in IDLE blocks accept.
    bus.in_valid = 1'b1;
    bus.a = 8'h01;
    bus.b = 8'h01;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_idle_busy", 32'(busy), 32'd0);
    chk("clr_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-RUN.
    send(8'h33, 8'h44, 9'h077, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_ov", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("arst_no_result", 32'(bad), 32'd0);
    chk("arst_ready_after", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back operations.
    bb[0] = '{8'h3C, 8'h42, 9'h07E};
    bb[1] = '{8'h80, 8'h80, 9'h100};
    bb[2] = '{8'h7F, 8'h01, 9'h080};
    bb[3] = '{8'hA5, 8'h5A, 9'h0FF};
    bb[4] = '{8'h00, 8'h00, 9'h000};
    bb[5] = '{8'hC8, 8'h64, 9'h12C};
    for (int i = 0; i < 6; i++) begin
      send(bb[i].a, bb[i].b, bb[i].r,
           1'b1, acc_t[i]);
    end
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    for (int i = 1; i < 6; i++) begin
      chk("b2b_period",
          32'(acc_t[i] - acc_t[i-1]), 32'd10);
    end
    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
